// File: rtl/pipelined_accum_adder.sv
`default_nettype none
// ============================================================================
// Module : pipelined_accum_adder
// Brief  : Streaming WIDTH-bit add/sub/accumulate unit, carry chain split
//          across STAGES registered chunks with valid/ready on both sides.
// Rev    : 1.0  initial release
// ============================================================================
module pipelined_accum_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic [WIDTH-1:0] acc
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    localparam logic [1:0] C_MODE_ADD  = 2'b00;
    localparam logic [1:0] C_MODE_SUB  = 2'b01;
    localparam logic [1:0] C_MODE_ACC  = 2'b10;
    localparam logic [1:0] C_MODE_LOAD = 2'b11;

    logic                         w_stall;
    logic                         w_accept;
    logic [WIDTH-1:0]             w_op2;
    logic [STAGES-1:0]            w_s_valid;
    logic [STAGES-1:0]            w_s_c;
    logic [STAGES-1:0]            w_s_sub;
    logic [STAGES-1:0]            w_s_accw;
    logic [STAGES-1:0][WIDTH-1:0] w_s_a;
    logic [STAGES-1:0][WIDTH-1:0] w_s_b;
    logic [WIDTH-1:0]             w_fin_res;
    logic                         w_fin_c;
    logic                         w_unused_b_hi;

    logic                         out_valid_q;
    logic [WIDTH:0]               sum_q;
    logic [WIDTH-1:0]             acc_q;
    logic                         acc_inflight_q;
    logic                         acc_inflight_d;

    assign w_stall  = out_valid_q && !out_ready;
    assign in_ready = !w_stall && !acc_inflight_q;
    assign w_accept = in_valid && in_ready;

    // Operand 2 is resolved at accept so later stages never look at mode or acc.
    always_comb begin
        w_op2 = B;
        case (mode)
            C_MODE_ADD:  w_op2 = B;
            C_MODE_SUB:  w_op2 = ~B;
            C_MODE_ACC:  w_op2 = acc_q;
            C_MODE_LOAD: w_op2 = '0;
            default:     w_op2 = B;
        endcase
    end

    assign w_s_valid[0] = w_accept;
    assign w_s_a[0]     = A;
    assign w_s_b[0]     = w_op2;
    assign w_s_c[0]     = (mode == C_MODE_SUB);
    assign w_s_sub[0]   = (mode == C_MODE_SUB);
    assign w_s_accw[0]  = (mode == C_MODE_ACC) || (mode == C_MODE_LOAD);

    // Operand A rotates right one chunk per stage, the finished result chunk
    // entering at the top; operand 2 shifts right so its next chunk is at bit 0.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK:0]   w_chunk;
        logic [WIDTH-1:0] w_a_next;

        assign w_chunk = {1'b0, w_s_a[k][CHUNK-1:0]} + {1'b0, w_s_b[k][CHUNK-1:0]}
                       + {{CHUNK{1'b0}}, w_s_c[k]};

        if (CHUNK == WIDTH) begin : g_whole
            assign w_a_next = w_chunk[CHUNK-1:0];
        end else begin : g_rot
            assign w_a_next = {w_chunk[CHUNK-1:0], w_s_a[k][WIDTH-1:CHUNK]};
        end

        if (k < LAST) begin : g_reg
            logic             valid_q;
            logic             c_q;
            logic             sub_q;
            logic             accw_q;
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    c_q     <= 1'b0;
                    sub_q   <= 1'b0;
                    accw_q  <= 1'b0;
                    a_q     <= '0;
                    b_q     <= '0;
                end else if (!w_stall) begin
                    valid_q <= w_s_valid[k];
                    if (w_s_valid[k]) begin
                        c_q    <= w_chunk[CHUNK];
                        sub_q  <= w_s_sub[k];
                        accw_q <= w_s_accw[k];
                        a_q    <= w_a_next;
                        b_q    <= {{CHUNK{1'b0}}, w_s_b[k][WIDTH-1:CHUNK]};
                    end
                end
            end

            assign w_s_valid[k+1] = valid_q;
            assign w_s_c[k+1]     = c_q;
            assign w_s_sub[k+1]   = sub_q;
            assign w_s_accw[k+1]  = accw_q;
            assign w_s_a[k+1]     = a_q;
            assign w_s_b[k+1]     = b_q;
        end else begin : g_out
            assign w_fin_res = w_a_next;
            assign w_fin_c   = w_chunk[CHUNK];
        end
    end

    // Above its low chunk the last stage's operand 2 only holds shifted-in zeros.
    assign w_unused_b_hi = &{1'b0, w_s_b[LAST]};

    always_comb begin
        acc_inflight_d = acc_inflight_q;
        if (w_accept && w_s_accw[0]) begin
            acc_inflight_d = 1'b1;
        end
        if (!w_stall && w_s_valid[LAST] && w_s_accw[LAST]) begin
            acc_inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q    <= 1'b0;
            sum_q          <= '0;
            acc_q          <= '0;
            acc_inflight_q <= 1'b0;
        end else begin
            acc_inflight_q <= acc_inflight_d;
            if (!w_stall) begin
                out_valid_q <= w_s_valid[LAST];
                if (w_s_valid[LAST]) begin
                    // SUB carries out when no borrow occurred, hence the flip.
                    sum_q <= {w_fin_c ^ w_s_sub[LAST], w_fin_res};
                    if (w_s_accw[LAST]) begin
                        acc_q <= w_fin_res;
                    end
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign acc       = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_accum_adder.sv
`default_nettype none
// ============================================================================
// Module : tb_pipelined_accum_adder
// Brief  : Scoreboard bench for pipelined_accum_adder (WIDTH=8, STAGES=2).
// Rev    : 1.0  initial release
// ============================================================================
module tb_pipelined_accum_adder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic [1:0] mode;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] sum;
    logic [7:0] acc;

    int         n_checks;
    int         n_errors;
    int         rx_count;
    logic [8:0] sb_q[$];
    logic [7:0] acc_m;

    pipelined_accum_adder #(.WIDTH(8), .STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .acc       (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_nonempty", sb_q.size(), 1);
            end else begin
                check_eq("sum", {23'd0, sum}, {23'd0, sb_q.pop_front()});
                rx_count++;
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                        output int waits);
        logic [8:0] e;
        bit         done;
        A        = a;
        B        = b;
        mode     = m;
        in_valid = 1'b1;
        waits    = 0;
        done     = 1'b0;
        while (!done && waits < 20) begin
            @(negedge clk);
            if (in_ready) begin
                case (m)
                    2'b00: e = {1'b0, a} + {1'b0, b};
                    2'b01: e = {(a < b), 8'(a - b)};
                    2'b10: begin
                        e     = {1'b0, acc_m} + {1'b0, a};
                        acc_m = e[7:0];
                    end
                    default: begin
                        e     = {1'b0, a};
                        acc_m = a;
                    end
                endcase
                sb_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (!done) waits++;
        end
        if (!done) check_eq("send_accepted", {31'd0, done}, 1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("drain_empty", sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w1, w2, w3;
        int rx_start;
        n_checks  = 0;
        n_errors  = 0;
        rx_count  = 0;
        acc_m     = 8'h00;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        A         = '0;
        B         = '0;
        mode      = 2'b00;
        out_ready = 1'b1;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", {31'd0, out_valid}, 0);
        check_eq("rst_sum", {23'd0, sum}, 0);
        check_eq("rst_acc", {24'd0, acc}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_in_ready", {31'd0, in_ready}, 1);

        // ADD stream: latency and back-to-back throughput
        send(8'hF0, 8'h20, 2'b00, w1);
        check_eq("add_ov_e1", {31'd0, out_valid}, 0);
        send(8'h02, 8'h03, 2'b00, w2);
        check_eq("add_ov_e2", {31'd0, out_valid}, 1);
        send(8'hFF, 8'hFF, 2'b00, w3);
        check_eq("add_ov_e3", {31'd0, out_valid}, 1);
        idle();
        check_eq("add_waits", w1 + w2 + w3, 0);
        @(posedge clk);
        #1;
        check_eq("add_ov_e4", {31'd0, out_valid}, 1);
        @(posedge clk);
        #1;
        check_eq("add_ov_e5", {31'd0, out_valid}, 0);
        drain();

        // SUB with and without borrow
        send(8'h05, 8'h07, 2'b01, w1);
        send(8'h07, 8'h05, 2'b01, w2);
        send(8'h00, 8'hFF, 2'b01, w3);
        idle();
        drain();

        // Accumulate: LOAD then two ACC, one-cycle interlock bubble each
        send(8'h80, 8'h00, 2'b11, w1);
        check_eq("acc_ir_after_load", {31'd0, in_ready}, 0);
        send(8'h90, 8'h55, 2'b10, w2);
        check_eq("acc_wait1", w2, 1);
        send(8'h01, 8'hAA, 2'b10, w3);
        check_eq("acc_wait2", w3, 1);
        idle();
        check_eq("acc_ir_low", {31'd0, in_ready}, 0);
        @(posedge clk);
        #1;
        check_eq("acc_ir_high", {31'd0, in_ready}, 1);
        drain();
        check_eq("acc_final", {24'd0, acc}, {24'd0, acc_m});

        // Backpressure: two beats held for three cycles
        rx_start  = rx_count;
        out_ready = 1'b0;
        send(8'h11, 8'h22, 2'b00, w1);
        send(8'h33, 8'h44, 2'b00, w2);
        idle();
        for (int i = 0; i < 3; i++) begin
            check_eq("bp_sum", {23'd0, sum}, 32'h033);
            check_eq("bp_in_ready", {31'd0, in_ready}, 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain();
        check_eq("bp_rx_count", rx_count - rx_start, 2);

        // Reset while an ACC beat is in flight
        send(8'h03, 8'h04, 2'b00, w1);
        send(8'h05, 8'h00, 2'b10, w2);
        idle();
        check_eq("pre_rst_ov", {31'd0, out_valid}, 1);
        rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", {31'd0, out_valid}, 0);
        check_eq("arst_acc", {24'd0, acc}, 0);
        sb_q.delete();
        acc_m = 8'h00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_rst_in_ready", {31'd0, in_ready}, 1);
        check_eq("post_rst_out_valid", {31'd0, out_valid}, 0);
        rx_start = rx_count;
        send(8'h01, 8'h01, 2'b00, w1);
        idle();
        drain();
        check_eq("post_rst_rx", rx_count - rx_start, 1);
        check_eq("post_rst_acc", {24'd0, acc}, {24'd0, acc_m});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
